// File: rtl/poly_mul_pkg.sv
// +----------------------------------------------------------------------+
// | poly_mul_pkg : shared types and constants for poly_mul_ctrl           |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package poly_mul_pkg;

  localparam int EQ = 13;
  localparam logic [EQ-1:0] COEF_MASK = 13'h1FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_S = 2'd1,
    MAC    = 2'd2,
    OUT    = 2'd3
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [2:0] mag;
  } sgnmag4_t;

  // Secret coefficients are bounded by 4; larger encodings clamp to 4.
  function automatic logic [2:0] sat_mag(input logic [2:0] m);
    return (m > 3'd4) ? 3'd4 : m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/poly_mul_ctrl_small_alu.sv
// +----------------------------------------------------------------------+
// | small_alu : acc_out = acc_in +/- a_in * |s|, modulo 2^13              |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module small_alu
  import poly_mul_pkg::*;
(
  input  logic [EQ-1:0] acc_in,
  input  logic [EQ-1:0] a_in,
  input  logic [2:0]    mag,
  input  logic          sign,
  output logic [EQ-1:0] acc_out
);

  logic [2:0]    mag_sat;
  logic [EQ+2:0] prod_full;
  logic [EQ-1:0] prod;

  // A negative zero contributes a zero product, so the sign is harmless there.
  always_comb begin
    mag_sat   = sat_mag(mag);
    prod_full = {3'b000, a_in} * {{EQ{1'b0}}, mag_sat};
    prod      = prod_full[EQ-1:0] & COEF_MASK;
    acc_out   = sign ? (acc_in - prod) : (acc_in + prod);
  end

endmodule

`default_nettype wire

// File: rtl/poly_mul_ctrl.sv
// +----------------------------------------------------------------------+
// | poly_mul_ctrl : negacyclic schoolbook multiply in Z_2^13[x]/(x^N+1)   |
// | Optional macro POLY_MUL_STALL_CNT_EN adds the stall_cnt output.       |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module poly_mul_ctrl
  import poly_mul_pkg::*;
#(
  parameter int N     = 256,
  parameter int LOG_N = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          keep_acc,
  input  logic          emit,
  output logic          busy,
  output logic          done,
  input  logic          s_valid,
  input  logic [3:0]    s_data,
  output logic          s_ready,
  input  logic          a_valid,
  input  logic [EQ-1:0] a_data,
  output logic          a_ready,
  output logic          res_valid,
  output logic [EQ-1:0] res_data,
`ifdef POLY_MUL_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  input  logic          res_ready
);

  state_t           state;
  logic             emit_en;
  logic [LOG_N-1:0] cnt;
  logic [LOG_N-1:0] cnt_next;
  logic             cnt_last;
  logic             s_fire;
  logic             a_fire;
  logic             r_fire;

  logic [EQ-1:0]    acc     [N];
  logic [EQ-1:0]    alu_out [N];
  sgnmag4_t         s_reg   [N];

  assign cnt_next = cnt + LOG_N'(1);
  assign cnt_last = (cnt == LOG_N'(N - 1));
  assign s_fire   = s_valid & s_ready;
  assign a_fire   = a_valid & a_ready;
  assign r_fire   = res_valid & res_ready;

  for (genvar gi = 0; gi < N; gi++) begin : g_alu
    small_alu u_alu (
      .acc_in  (acc[gi]),
      .a_in    (a_data),
      .mag     (s_reg[gi].mag),
      .sign    (s_reg[gi].sign),
      .acc_out (alu_out[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      emit_en   <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_ready   <= 1'b0;
      a_ready   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int i = 0; i < N; i++) begin
        acc[i]   <= '0;
        s_reg[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            emit_en <= emit;
            cnt     <= '0;
            busy    <= 1'b1;
            s_ready <= 1'b1;
            state   <= LOAD_S;
            if (!keep_acc) begin
              for (int i = 0; i < N; i++) acc[i] <= '0;
            end
          end
        end

        LOAD_S: begin
          // Shift toward index 0 so the first coefficient ends up in s_reg[0].
          if (s_fire) begin
            for (int i = 0; i < N - 1; i++) s_reg[i] <= s_reg[i+1];
            s_reg[N-1] <= sgnmag4_t'(s_data);
            cnt        <= cnt_next;
            if (cnt_last) begin
              s_ready <= 1'b0;
              a_ready <= 1'b1;
              state   <= MAC;
            end
          end
        end

        MAC: begin
          if (a_fire) begin
            for (int i = 0; i < N; i++) acc[i] <= alu_out[i];
            // Multiplying s by x: the coefficient wrapping past x^N flips sign.
            for (int i = 1; i < N; i++) s_reg[i] <= s_reg[i-1];
            s_reg[0] <= '{sign: ~s_reg[N-1].sign, mag: s_reg[N-1].mag};
            cnt      <= cnt_next;
            if (cnt_last) begin
              a_ready <= 1'b0;
              if (emit_en) begin
                res_valid <= 1'b1;
                res_data  <= alu_out[0];
                state     <= OUT;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end

        OUT: begin
          if (r_fire) begin
            cnt <= cnt_next;
            if (cnt_last) begin
              res_valid <= 1'b0;
              res_data  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              res_data <= acc[cnt_next];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef POLY_MUL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (((state == MAC) && !a_valid) ||
                 ((state == OUT) && res_valid && !res_ready)) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_poly_mul_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_poly_mul_ctrl : randomized bench against a negacyclic convolution  |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_poly_mul_ctrl;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst, start, keep_acc, emit;
  logic        busy, done;
  logic        s_valid, s_ready;
  logic [3:0]  s_data;
  logic        a_valid, a_ready;
  logic [12:0] a_data;
  logic        res_valid, res_ready;
  logic [12:0] res_data;
`ifdef POLY_MUL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  s_code    [N];
  logic [12:0] a_vec     [N];
  int          model_acc [N];
  logic [12:0] res_got   [N];

  always #5 clk = ~clk;

  poly_mul_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .keep_acc  (keep_acc),
    .emit      (emit),
    .busy      (busy),
    .done      (done),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
`ifdef POLY_MUL_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .res_ready (res_ready)
  );

  function automatic int sval(input logic [3:0] c);
    int m;
    m = (c[2:0] > 3'd4) ? 4 : int'(c[2:0]);
    return c[3] ? -m : m;
  endfunction

  // c(x) += a(x) * s(x) mod (x^N + 1), coefficients mod 2^13
  task automatic model_mac(input bit keep);
    int p;
    if (!keep) for (int i = 0; i < N; i++) model_acc[i] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        p = int'(a_vec[i]) * sval(s_code[j]);
        if (i + j < N) model_acc[i+j]     += p;
        else           model_acc[i+j-N]   -= p;
      end
    for (int i = 0; i < N; i++) model_acc[i] = ((model_acc[i] % 8192) + 8192) % 8192;
  endtask

  task automatic run_job(input bit keep, input bit em, input int gap_pct, input int stall_pct,
                         input int abort_beat, input int mid_start_at,
                         output int edges, output int stalls, output int nres);
    int sidx, aidx, k;
    bit prev_stall;
    logic [12:0] prev_data;
    sidx = 0; aidx = 0; k = 0; edges = 0; stalls = 0; nres = 0;
    prev_stall = 1'b0; prev_data = '0;
    if (abort_beat < 0) model_mac(keep);
    @(posedge clk); #1;
    start = 1'b1; keep_acc = keep; emit = em;
    forever begin
      @(posedge clk); #1;
      edges++;
      start = (edges == mid_start_at); keep_acc = 1'b0; emit = 1'b1;
      if (done) break;
      if (edges > 40 * N) begin
        compared++; mismatched++;
        $display("FAIL job_timeout: edges=%0d limit=%0d", edges, 40 * N);
        break;
      end
      if (prev_stall && res_valid) begin
        compared++;
        if (res_data !== prev_data) begin
          mismatched++;
          $display("FAIL stall_hold k=%0d: got %0d want %0d", k, res_data, prev_data);
        end
      end
      prev_stall = 1'b0;
      if (abort_beat >= 0 && a_ready && aidx == abort_beat) begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        compared++;
        if ({busy, done, s_ready, a_ready, res_valid, res_data} !== 18'd0) begin
          mismatched++;
          $display("FAIL mid_reset_outputs: got %b want 0",
                   {busy, done, s_ready, a_ready, res_valid, res_data});
        end
`ifdef POLY_MUL_STALL_CNT_EN
        compared++;
        if (stall_cnt !== 16'd0) begin
          mismatched++;
          $display("FAIL mid_reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        return;
      end
      s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
      s_data = 4'($urandom); a_data = 13'($urandom);
      if (s_ready && sidx < N) begin
        s_valid = ($urandom_range(99) >= gap_pct);
        if (s_valid) begin s_data = s_code[sidx]; sidx++; end
      end
      if (a_ready && aidx < N) begin
        a_valid = ($urandom_range(99) >= gap_pct);
        if (a_valid) begin a_data = a_vec[aidx]; aidx++; end
        else stalls++;
      end
      if (res_valid) begin
        nres++;
        res_ready = ($urandom_range(99) >= stall_pct);
        if (res_ready) begin
          compared++;
          if (k >= N) begin
            mismatched++;
            $display("FAIL result_extra: got index %0d want < %0d", k, N);
          end else begin
            res_got[k] = res_data;
            if (res_data !== 13'(model_acc[k])) begin
              mismatched++;
              $display("FAIL result c[%0d]: got %0d want %0d", k, res_data, model_acc[k]);
            end
          end
          k++;
        end else begin
          stalls++; prev_stall = 1'b1; prev_data = res_data;
        end
      end
    end
    start = 1'b0; s_valid = 1'b0; a_valid = 1'b0; res_ready = 1'b0;
    if (em && edges <= 40 * N) begin
      compared++;
      if (k != N) begin
        mismatched++;
        $display("FAIL result_count: got %0d want %0d", k, N);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; keep_acc = 1'b0; emit = 1'b0;
    s_valid = 1'b0; s_data = '0; a_valid = 1'b0; a_data = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      mismatched++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
    end
    compared++;
    if (s_ready !== 1'b0 || a_ready !== 1'b0) begin
      mismatched++; $display("FAIL reset_ready: got %b%b want 00", s_ready, a_ready);
    end
    compared++;
    if (res_valid !== 1'b0 || res_data !== 13'd0) begin
      mismatched++; $display("FAIL reset_res: got %b/%0d want 0/0", res_valid, res_data);
    end
`ifdef POLY_MUL_STALL_CNT_EN
    compared++;
    if (stall_cnt !== 16'd0) begin
      mismatched++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_delta();
    int e, st, nr;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'h0; a_vec[i] = 13'(i); end
    s_code[0] = 4'b0001;
    run_job(1'b0, 1'b1, 0, 0, -1, -1, e, st, nr);
    compared++;
    if (e != 3 * N + 1) begin
      mismatched++; $display("FAIL delta_latency: got %0d want %0d", e, 3 * N + 1);
    end
    for (int k = 0; k < N; k++) begin
      compared++;
      if (res_got[k] !== 13'(k)) begin
        mismatched++; $display("FAIL delta c[%0d]: got %0d want %0d", k, res_got[k], k);
      end
    end
    @(posedge clk); #1;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_negacyclic();
    int e, st, nr;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'h0; a_vec[i] = 13'd0; end
    s_code[1] = 4'b0001;
    a_vec[N-1] = 13'd5;
    run_job(1'b0, 1'b1, 0, 0, -1, -1, e, st, nr);
    compared++;
    if (res_got[0] !== 13'd8187) begin
      mismatched++; $display("FAIL negacyclic c[0]: got %0d want 8187", res_got[0]);
    end
  endtask

  task automatic test_all_neg();
    int e, st, nr;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'b1100; a_vec[i] = 13'd8191; end
    run_job(1'b0, 1'b1, 0, 0, -1, -1, e, st, nr);
    compared++;
    if (res_got[0] !== 13'd7176 || res_got[N-1] !== 13'd1024) begin
      mismatched++;
      $display("FAIL all_neg ends: got %0d,%0d want 7176,1024", res_got[0], res_got[N-1]);
    end
  endtask

  task automatic test_keep_acc();
    int e, st, nr;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'h0; a_vec[i] = 13'd1; end
    s_code[0] = 4'b0001;
    run_job(1'b0, 1'b0, 0, 0, -1, -1, e, st, nr);
    compared++;
    if (nr != 0 || e != 2 * N + 1) begin
      mismatched++; $display("FAIL no_emit_job: got res=%0d edges=%0d want 0 %0d", nr, e, 2 * N + 1);
    end
    run_job(1'b1, 1'b1, 0, 0, -1, -1, e, st, nr);
    for (int k = 0; k < N; k++) begin
      compared++;
      if (res_got[k] !== 13'd2) begin
        mismatched++; $display("FAIL keep_acc c[%0d]: got %0d want 2", k, res_got[k]);
      end
    end
  endtask

  task automatic test_random();
    int e, st, nr;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) begin s_code[i] = 4'($urandom); a_vec[i] = 13'($urandom); end
      run_job(r[0], 1'b1, 30, 40, -1, -1, e, st, nr);
`ifdef POLY_MUL_STALL_CNT_EN
      compared++;
      if (stall_cnt !== 16'(st)) begin
        mismatched++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, st);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int e, st, nr;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'($urandom); a_vec[i] = 13'($urandom); end
    run_job(1'b0, 1'b1, 0, 0, 100, -1, e, st, nr);
    for (int i = 0; i < N; i++) model_acc[i] = 0;
    for (int i = 0; i < N; i++) begin s_code[i] = 4'($urandom); a_vec[i] = 13'($urandom); end
    run_job(1'b1, 1'b1, 10, 20, -1, N + 50, e, st, nr);
  endtask

  initial begin
    test_reset();
    test_delta();
    test_negacyclic();
    test_all_neg();
    test_keep_acc();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/poly_mul_ctrl.md
Name: poly_mul_ctrl

Overview:
Sequencer for negacyclic schoolbook polynomial multiplication in Z_2^13[x]/(x^N+1). This is the core operation of Saber matrix-vector and inner products.
- Holds a small secret polynomial s (sign-magnitude, |s| <= 4) in a rotating register.
- Broadcasts one public coefficient a[j] per accepted beat to N parallel small_alu instances, each owning one 13-bit accumulator.
- Streams the accumulated product out coefficient by coefficient.
- Sits between the coefficient memory/unpacker and the rounding/packing stage.

Parameters:
N, 256, polynomial length; a power of two, >= 4.
LOG_N, $clog2(N), width of the beat/index counters.

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
keep_acc  in  1  sampled with start; 1 = do not clear accumulators
emit  in  1  sampled with start; 1 = stream results after MAC
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job finishes
s_valid  in  1  secret coefficient valid
s_data  in  4  {sign, mag[2:0]}; coefficient index 0 first
s_ready  out  1  high only in LOAD_S
a_valid  in  1  public coefficient valid
a_data  in  13  a[j]; j = 0 first
a_ready  out  1  high only in MAC
res_valid  out  1  result valid
res_data  out  13  c[k]; k = 0 first
res_ready  in  1  downstream accept

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, a_ready=0, res_valid=0, res_data=0. All accumulators = 0, s register = 0, counters = 0, state = IDLE.
- FSM: IDLE -> LOAD_S -> MAC -> (OUT if emit) -> IDLE.
  - IDLE: start=1 latches keep_acc and emit. If keep_acc=0, all accumulators are cleared in the same edge. Next state is LOAD_S, so s_ready=1 on the next cycle. start while busy is ignored.
  - LOAD_S: each s handshake shifts s_data in. After N beats, s_reg[i] = s[i]. Counter wraps to 0, then MAC.
  - MAC: each a handshake (a_valid & a_ready) does, for all i in one cycle: acc[i] <= small_alu(acc[i], a_data, s_reg[i].mag, s_reg[i].sign).
    - In the same edge the s register rotates negacyclically: s_reg[i] <= s_reg[i-1] for i > 0; s_reg[0] <= {~s_reg[N-1].sign, s_reg[N-1].mag}.
    - Cycles without a handshake change nothing.
    - After beat N-1, go to OUT if emit, else go to IDLE with done=1.
  - OUT: res_data = acc[k], res_valid=1. k advances on each res_valid & res_ready. Data is held stable while stalled. After beat N-1, go to IDLE with done=1 in that transition cycle.
- Accumulators are not modified in OUT. After N rotations the s register equals the negated original; it is not reused.
- Arithmetic is modulo 2^13; wrap-around is silent.
- mag values 5..7 act as 4. -0 is treated as 0.
- done is asserted in the first IDLE cycle, one cycle after the final handshake edge. A start in that same cycle is accepted.
- Reset asserted in any state returns to reset values on the next edge. The partially accumulated job is discarded.
- Latency for a job with no stalls: 1 + N + N (+ N if emit) cycles from start to done.

Optional Feature:
POLY_MUL_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. It counts cycles spent in MAC with a_valid=0, plus cycles in OUT with res_valid & !res_ready. It saturates at 65535, clears on an accepted start, and is reset to 0 by rst.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package poly_mul_pkg:
  - state enum {IDLE, LOAD_S, MAC, OUT}
  - typedef sgnmag4_t {sign, mag[2:0]}
  - constants EQ=13, COEF_MASK
- Sub-module: N instances of the existing small_alu, generated in a loop.
- FSM, counters, s register and accumulators stay in poly_mul_ctrl.

Test Plan:
1. s = delta (s[0]=+1, rest 0); a[j]=j; emit=1 -> c[k]=k for all k; done after 3N+1 cycles with no stalls.
2. s[1]=+1, rest 0; a[N-1]=5, rest 0 -> c[0]=8187 (-5 mod 2^13); all others 0 (checks the negacyclic sign flip).
3. s all {1,4} (-4); a all 8191 (-1) -> c[k]=(8k-1016) mod 8192, i.e. c[0]=7176, c[255]=1024.
4. Run 1: keep_acc=0, emit=0, delta s, a all 1; done with no res_valid. Run 2: keep_acc=1, emit=1, same s and a -> every c[k]=2.
5. Random a_valid gaps and res_ready toggling, random s and a -> results match a golden model; res_data stable under stall; with the macro defined, stall_cnt equals the number of injected stall cycles.
6. rst asserted after MAC beat 100 -> next cycle all outputs at reset values and state IDLE; a following full job matches the golden model, and start pulsed mid-job is ignored.
